// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if
// Bundles the three channels around the command sequencer: the upstream
// command handshake, the registered drive of (and result back from) the
// combinational alu_block, and the downstream response handshake.
//   cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op : command in (valid/ready)
//   alu_a/alu_b/alu_s, alu_result          : ALU operands out, result in
//   rsp_valid/rsp_ready/rsp_result/rsp_op/rsp_seq : response out (valid/ready)
// The slave modport is the sequencer's view; master is the environment's.
interface alu_cmd_sequencer_if #(
    parameter int W = 4
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [1:0]   cmd_op;

    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_s;
    logic [W-1:0] alu_result;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic [1:0]   rsp_op;
    logic [7:0]   rsp_seq;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_s, rsp_valid, rsp_result, rsp_op, rsp_seq
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_s, rsp_valid, rsp_result, rsp_op, rsp_seq
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Command stage in front of the purely combinational alu_block. Commands are
// buffered in a DEPTH-entry FIFO, issued one at a time on registered
// alu_a/alu_b/alu_s, given one cycle to settle, and the result is captured
// and offered downstream with a wrapping 8-bit sequence number.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_cmd_sequencer_if.slave (command, ALU and response channels)
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_cmd_sequencer_if.slave   bus
);
    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]    CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0]  PTR_ONE    = AW'(1);

    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

    state_t            state_q, state_d;
    logic [2*W+1:0]    mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic [W-1:0]      alu_a_q, alu_a_d;
    logic [W-1:0]      alu_b_q, alu_b_d;
    logic [1:0]        alu_s_q, alu_s_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [W-1:0]      rsp_result_q, rsp_result_d;
    logic [1:0]        rsp_op_q, rsp_op_d;
    logic [7:0]        rsp_seq_q, rsp_seq_d;

    logic              full, empty, ready, push, pop;
    logic [2*W+1:0]    head;

    // Readiness is held low during reset so nothing offered then is taken.
    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign ready = !full && !rst;
    assign push  = bus.cmd_valid && ready;
    assign head  = mem_q[rd_ptr_q];

    assign bus.cmd_ready  = ready;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_s      = alu_s_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_op     = rsp_op_q;
    assign bus.rsp_seq    = rsp_seq_q;

    // FIFO storage: entries are packed as {op, b, a}; no reset needed because
    // the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.cmd_op, bus.cmd_b, bus.cmd_a};
        end
    end

    // FIFO bookkeeping: pointers wrap naturally since DEPTH is a power of two;
    // a simultaneous push and pop move both pointers but leave the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sequencer: IDLE pops and drives the ALU, DRIVE waits one cycle for the
    // combinational result to settle and captures it, HOLD offers it until
    // the downstream side takes it. Capturing rsp_op from alu_s_q (not the
    // FIFO) ties the reported op to the operands that produced the result.
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_s_d      = alu_s_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_op_d     = rsp_op_q;
        rsp_seq_d    = rsp_seq_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    alu_a_d = head[W-1:0];
                    alu_b_d = head[2*W-1:W];
                    alu_s_d = head[2*W+1:2*W];
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                rsp_result_d = bus.alu_result;
                rsp_op_d     = alu_s_q;
                rsp_valid_d  = 1'b1;
                state_d      = HOLD;
            end
            HOLD: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_seq_d   = rsp_seq_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight or pending work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_s_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_op_q     <= '0;
            rsp_seq_q    <= '0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_s_q      <= alu_s_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_op_q     <= rsp_op_d;
            rsp_seq_q    <= rsp_seq_d;
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
// Directed bench for alu_cmd_sequencer (DEPTH=4, W=4). A small behavioural
// alu_block sits on the ALU channel. Inputs change and outputs are sampled on
// the falling edge; the DUT acts on the rising edge.
module tb_alu_cmd_sequencer;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;

    alu_cmd_sequencer_if #(.W(4)) bus ();

    alu_cmd_sequencer #(.DEPTH(4), .W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference behaviour of alu_block.
    function automatic logic [3:0] aluRef(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] op);
        logic [3:0] r;
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = {1'b0, a > b, a < b, a == b};
            default: r = a & b;
        endcase
        return r;
    endfunction

    // Behavioural alu_block driven by the registered operands.
    always_comb bus.alu_result = aluRef(bus.alu_a, bus.alu_b, bus.alu_s);

    // Clock and a free-running cycle count used for spacing checks.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Global time limit so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [3:0] bpA   [5] = '{4'h1, 4'h5, 4'h7, 4'h8, 4'h2};
    logic [3:0] bpB   [5] = '{4'h2, 4'h3, 4'h7, 4'h1, 4'h9};
    logic [1:0] bpOp  [5] = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b10};
    logic [3:0] bpRes [5] = '{4'h3, 4'h2, 4'h7, 4'h9, 4'h2};

    logic [3:0] sA  [300];
    logic [3:0] sB  [300];
    logic [1:0] sOp [300];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One command end-to-end, checking the 2-cycle latency and the response.
    task automatic singleCmd(input string tag, input logic [3:0] a, input logic [3:0] b,
                             input logic [1:0] op, input logic [3:0] expRes,
                             input logic [7:0] expSeq);
        int n;
        bus.rsp_ready = 1'b0;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = op;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checkOutput({tag, "_valid_e0"}, 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_alu_a"}, 32'(bus.alu_a), 32'(a));
        checkOutput({tag, "_alu_s"}, 32'(bus.alu_s), 32'(op));
        checkOutput({tag, "_valid_e1"}, 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_valid_e2"}, 32'(bus.rsp_valid), 32'd1);
        checkOutput({tag, "_result"}, 32'(bus.rsp_result), 32'(expRes));
        checkOutput({tag, "_op"}, 32'(bus.rsp_op), 32'(op));
        checkOutput({tag, "_seq"}, 32'(bus.rsp_seq), 32'(expSeq));
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_valid_done"}, 32'(bus.rsp_valid), 32'd0);
        bus.rsp_ready = 1'b0;
    endtask

    // Holds cmd_valid high for a number of cycles, offering the backpressure
    // vectors in order, and reports how many were taken.
    task automatic applyStimulus(input int cycles, output int accepted);
        accepted = 0;
        for (int c = 0; c < cycles; c++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_a     = bpA[accepted % 5];
            bus.cmd_b     = bpB[accepted % 5];
            bus.cmd_op    = bpOp[accepted % 5];
            if (bus.cmd_ready) accepted++;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
    endtask

    // Streams n random commands with rsp_ready high; responses are checked in
    // order against the reference, including 3-cycle spacing and sequence.
    task automatic streamRun(input string tag, input int n, input logic [7:0] seqStart);
        for (int i = 0; i < n; i++) begin
            sA[i]  = 4'($urandom_range(15, 0));
            sB[i]  = 4'($urandom_range(15, 0));
            sOp[i] = 2'($urandom_range(3, 0));
        end
        bus.rsp_ready = 1'b1;
        fork
            begin : producer
                int k;
                int guard;
                k = 0;
                guard = 0;
                while (k < n && guard < 4000) begin
                    bus.cmd_valid = 1'b1;
                    bus.cmd_a     = sA[k];
                    bus.cmd_b     = sB[k];
                    bus.cmd_op    = sOp[k];
                    if (bus.cmd_ready) k++;
                    @(negedge clk);
                    guard++;
                end
                bus.cmd_valid = 1'b0;
                checkOutput({tag, "_push_count"}, 32'(k), 32'(n));
            end
            begin : consumer
                int j;
                int g;
                int lastCyc;
                logic [7:0] expSeq;
                j = 0;
                g = 0;
                lastCyc = 0;
                expSeq = seqStart;
                while (j < n && g < 4000) begin
                    @(negedge clk);
                    g++;
                    if (bus.rsp_valid) begin
                        checkOutput({tag, "_result"}, 32'(bus.rsp_result),
                                    32'(aluRef(sA[j], sB[j], sOp[j])));
                        checkOutput({tag, "_op"}, 32'(bus.rsp_op), 32'(sOp[j]));
                        checkOutput({tag, "_seq"}, 32'(bus.rsp_seq), 32'(expSeq));
                        if (j > 0) checkOutput({tag, "_spacing"}, 32'(cyc - lastCyc), 32'd3);
                        lastCyc = cyc;
                        expSeq  = expSeq + 8'd1;
                        j++;
                    end
                end
                checkOutput({tag, "_rsp_count"}, 32'(j), 32'(n));
            end
        join
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int acc;
        int j;
        int g;
        int stale;
        total = 0;
        bad   = 0;

        // Reset with a command offered; it must be ignored.
        rst           = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = 4'hF;
        bus.cmd_b     = 4'hF;
        bus.cmd_op    = 2'b00;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_alu_a", 32'(bus.alu_a), 32'd0);
        checkOutput("rst_rsp_seq", 32'(bus.rsp_seq), 32'd0);
        checkOutput("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
        bus.cmd_valid = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        checkOutput("post_rst_alu_a", 32'(bus.alu_a), 32'd0);
        checkOutput("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);

        // Four single commands, A=1100 B=0011.
        singleCmd("add", 4'b1100, 4'b0011, 2'b00, 4'b1111, 8'd0);
        singleCmd("sub", 4'b1100, 4'b0011, 2'b01, 4'b1001, 8'd1);
        singleCmd("cmp", 4'b1100, 4'b0011, 2'b10, 4'b0100, 8'd2);
        singleCmd("and", 4'b1100, 4'b0011, 2'b11, 4'b0000, 8'd3);

        // Wrap cases.
        singleCmd("add_wrap", 4'b1001, 4'b1001, 2'b00, 4'b0010, 8'd4);
        singleCmd("sub_wrap", 4'b0011, 4'b1100, 2'b01, 4'b0111, 8'd5);
        singleCmd("cmp_eq", 4'b0101, 4'b0101, 2'b10, 4'b0001, 8'd6);

        // Backpressure: exactly DEPTH+1 accepted, response held steady.
        applyStimulus(12, acc);
        checkOutput("bp_accepted", 32'(acc), 32'd5);
        checkOutput("bp_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
        checkOutput("bp_valid", 32'(bus.rsp_valid), 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("bp_hold_result", 32'(bus.rsp_result), 32'(bpRes[0]));
        checkOutput("bp_hold_op", 32'(bus.rsp_op), 32'(bpOp[0]));
        checkOutput("bp_hold_seq", 32'(bus.rsp_seq), 32'd7);
        checkOutput("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);

        // Release: first response taken now, pop from full next edge after.
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_ready_after_hold", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        checkOutput("bp_ready_after_pop", 32'(bus.cmd_ready), 32'd1);
        j = 1;
        g = 0;
        while (j < 5 && g < 40) begin
            @(negedge clk);
            g++;
            if (bus.rsp_valid) begin
                checkOutput("bp_drain_result", 32'(bus.rsp_result), 32'(bpRes[j]));
                checkOutput("bp_drain_op", 32'(bus.rsp_op), 32'(bpOp[j]));
                checkOutput("bp_drain_seq", 32'(bus.rsp_seq), 32'(7 + j));
                j++;
            end
        end
        checkOutput("bp_drain_count", 32'(j), 32'd5);
        @(negedge clk);

        // Streaming: 20 random commands, seq continues from 12.
        streamRun("stream", 20, 8'd12);

        // Reset while in DRIVE with three commands still queued.
        applyStimulus(12, acc);
        checkOutput("rstmid_accepted", 32'(acc), 32'd5);
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstmid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rstmid_cmd_ready_in_rst", 32'(bus.cmd_ready), 32'd0);
        checkOutput("rstmid_seq", 32'(bus.rsp_seq), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rstmid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.alu_a != 4'h0) stale++;
        end
        checkOutput("rstmid_stale", 32'(stale), 32'd0);
        singleCmd("rstmid_next", 4'b0110, 4'b0010, 2'b01, 4'b0100, 8'd0);

        // Sequence wrap: responses numbered 1..255, 0, 1.
        streamRun("seqwrap", 257, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
